audio_rec_play_ctrl: RTL and testbench
======================================

Name: audio_rec_play_ctrl

Overview:
- Sits directly downstream of the key-debounce stage. Consumes record_en, play_en, sdr_waddr_set and sdr_raddr_set.
- Record: moves codec ADC samples into SDRAM as single-word write requests.
- Play: prefetches recorded words from SDRAM and hands them to the codec DAC path on each sample request.
- Tracks the recorded length so playback stops at the end of the recording.

Parameters:
- ADDR_W, 22, SDRAM word-address width.
- DATA_W, 32, sample word width (L16 in [31:16], R16 in [15:0]).
- MAX_ADDR, 22'h3FFFFF, last writable word address. Must be < 2^ADDR_W.

Ports:
- clk50M  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- record_en  in  1  level: recording enabled.
- play_en  in  1  level: playback enabled.
- sdr_waddr_set  in  1  level: clear write address and record length.
- sdr_raddr_set  in  1  level: clear read address.
- adc_data  in  DATA_W  captured ADC sample.
- adc_valid  in  1  one-cycle strobe per ADC sample.
- dac_req  in  1  one-cycle strobe: DAC wants the next sample.
- dac_data  out  DATA_W  sample to DAC, held between updates.
- dac_valid  out  1  one-cycle strobe, dac_data updated.
- sdr_wr_req  out  1  write request, held until ack.
- sdr_wr_addr  out  ADDR_W  write word address.
- sdr_wr_data  out  DATA_W  write data.
- sdr_wr_ack  in  1  one-cycle write accept.
- sdr_rd_req  out  1  read request, held until ack.
- sdr_rd_addr  out  ADDR_W  read word address.
- sdr_rd_ack  in  1  one-cycle read accept.
- sdr_rd_data  in  DATA_W  read data.
- sdr_rd_valid  in  1  one-cycle read data strobe, arrives ≥1 cycle after ack.
- rec_len  out  ADDR_W  number of words recorded.
- rec_full  out  1  sticky: buffer filled.
- overrun  out  1  sticky: ADC sample dropped.
- underrun  out  1  sticky: dac_req arrived with no prefetched word.
- play_done  out  1  level: read address reached rec_len.

Behaviour:
- Reset: all outputs 0; waddr=raddr=0; prefetch empty; state IDLE.
- Clear pulses:
  - sdr_waddr_set=1 (in any state): waddr, rec_len, rec_full and overrun clear next cycle.
  - sdr_raddr_set=1: raddr, prefetch-valid, underrun and play_done clear.
  - Either clear is ignored while the matching request is outstanding. It takes effect on the first cycle after the ack or rd_valid.
- States: IDLE, REC_IDLE, REC_WR, PLAY_FETCH, PLAY_WAIT, PLAY_READY.
- Mode priority: if record_en and play_en are both 1, recording wins.
- IDLE:
  - record_en → REC_IDLE.
  - else play_en → PLAY_FETCH.
- REC_IDLE:
  - adc_valid with waddr ≤ MAX_ADDR and !rec_full: latch adc_data into sdr_wr_data, sdr_wr_addr=waddr, sdr_wr_req=1 → REC_WR.
  - adc_valid with rec_full: sample ignored.
  - record_en=0 → IDLE.
- REC_WR:
  - Hold req, addr and data stable until sdr_wr_ack.
  - On ack: req=0; waddr and rec_len increment.
  - If waddr was MAX_ADDR on that ack: rec_full=1, waddr holds.
  - Then → REC_IDLE, or → IDLE if record_en=0.
  - adc_valid while in REC_WR: sample dropped, overrun=1.
- PLAY_FETCH:
  - play_en=0 → IDLE.
  - raddr==rec_len: play_done=1, stay, no request.
  - else: sdr_rd_req=1, sdr_rd_addr=raddr.
  - On sdr_rd_ack: req=0 → PLAY_WAIT.
- PLAY_WAIT:
  - On sdr_rd_valid: prefetch=sdr_rd_data, valid=1, raddr+1 → PLAY_READY.
  - play_en dropping here is ignored until rd_valid arrives. Then → IDLE with prefetch retained.
- PLAY_READY:
  - On dac_req: dac_data=prefetch, dac_valid=1 (next cycle), valid=0 → PLAY_FETCH.
  - play_en=0 → IDLE.
- dac_req with no valid prefetch (any state): dac_data=0, dac_valid=1, underrun=1. Exception: when play_done=1 the output is silence and underrun is not set.
- Outstanding requests are never withdrawn; a mode exit always waits for ack (and rd_valid for reads).
- Addresses are unsigned and compared at ADDR_W bits. Without LOOP_PLAY_EN there is no wrap.
- Latency: adc_valid → sdr_wr_req asserted is 1 cycle. dac_req → dac_valid is 1 cycle.

Optional Feature:
- Macro LOOP_PLAY_EN.
- Defined: when raddr reaches rec_len (rec_len ≠ 0), raddr wraps to 0 and fetching continues, so playback loops. play_done is never asserted.
- Undefined: playback stops at rec_len with play_done=1 and outputs silence.

Test Plan:
- Record 4 samples: pulse sdr_waddr_set, then record_en=1, then adc_valid ×4 with data 0x11110000..0x44440000 and ack after 3 cycles each. Required: 4 writes at addr 0..3 with matching data; rec_len=4; overrun=0.
- Overrun: adc_valid twice 2 cycles apart, ack delayed 5 cycles. Required: one write only; overrun=1; rec_len=1.
- Playback: after the 4-sample recording, pulse sdr_raddr_set, then play_en=1 and dac_req every 20 cycles. Required: dac_data sequence 0x11110000..0x44440000, then 0 with play_done=1 and underrun=0.
- Underrun: dac_req issued while PLAY_WAIT with rd_valid delayed 30 cycles. Required: dac_data=0, dac_valid=1, underrun=1. The next dac_req returns the fetched word.
- Full: MAX_ADDR=3, 5 adc_valid. Required: 4 writes; rec_full=1; waddr holds at 3; no 5th request.
- Async reset mid-REC_WR (req held): all outputs 0 immediately, state IDLE. With LOOP_PLAY_EN defined and rec_len=2: play yields 0,1,0,1… with play_done=0.

Source files
------------

// File: rtl/audio_rec_play_ctrl_if.sv
// SDRAM single-word request bus between the record/play controller and the SDRAM arbiter.
// Latency: none, wires only.
// Backpressure: each request is held by the master until the matching one-cycle ack.
interface audio_rec_play_ctrl_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic              sdr_wr_req;
  logic [ADDR_W-1:0] sdr_wr_addr;
  logic [DATA_W-1:0] sdr_wr_data;
  logic              sdr_wr_ack;
  logic              sdr_rd_req;
  logic [ADDR_W-1:0] sdr_rd_addr;
  logic              sdr_rd_ack;
  logic [DATA_W-1:0] sdr_rd_data;
  logic              sdr_rd_valid;

  modport master (
    output sdr_wr_req, sdr_wr_addr, sdr_wr_data,
    input  sdr_wr_ack,
    output sdr_rd_req, sdr_rd_addr,
    input  sdr_rd_ack, sdr_rd_data, sdr_rd_valid
  );

  modport slave (
    input  sdr_wr_req, sdr_wr_addr, sdr_wr_data,
    output sdr_wr_ack,
    input  sdr_rd_req, sdr_rd_addr,
    output sdr_rd_ack, sdr_rd_data, sdr_rd_valid
  );
endinterface

// File: rtl/audio_rec_play_ctrl.sv
// Record ADC samples to SDRAM and play them back to the DAC; LOOP_PLAY_EN makes playback wrap.
// Latency: adc_valid -> sdr_wr_req 1 cycle; dac_req -> dac_valid 1 cycle.
// Backpressure: SDRAM requests held until ack; ADC samples arriving during a write are dropped (overrun).
module audio_rec_play_ctrl #(
  parameter int                ADDR_W   = 22,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 22'h3FFFFF
) (
  input  logic                  clk50M,
  input  logic                  reset_n,
  input  logic                  record_en,
  input  logic                  play_en,
  input  logic                  sdr_waddr_set,
  input  logic                  sdr_raddr_set,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  input  logic                  dac_req,
  output logic [DATA_W-1:0]     dac_data,
  output logic                  dac_valid,
  audio_rec_play_ctrl_if.master sdr,
  output logic [ADDR_W-1:0]     rec_len,
  output logic                  rec_full,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  play_done
);

  typedef enum logic [2:0] {
    IDLE,
    REC_IDLE,
    REC_WR,
    PLAY_FETCH,
    PLAY_WAIT,
    PLAY_READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] pf_data;
  logic              pf_vld;
  logic              wclr;
  logic              rclr;

  // Address clears wait until no request of the matching direction is in flight;
  // a read is in flight from request until its data returns.
  assign wclr = sdr_waddr_set && !sdr.sdr_wr_req;
  assign rclr = sdr_raddr_set && !sdr.sdr_rd_req && (state != PLAY_WAIT);

  // Mode FSM, SDRAM request generation, DAC service and status flags.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      waddr           <= '0;
      raddr           <= '0;
      pf_data         <= '0;
      pf_vld          <= 1'b0;
      dac_data        <= '0;
      dac_valid       <= 1'b0;
      sdr.sdr_wr_req  <= 1'b0;
      sdr.sdr_wr_addr <= '0;
      sdr.sdr_wr_data <= '0;
      sdr.sdr_rd_req  <= 1'b0;
      sdr.sdr_rd_addr <= '0;
      rec_len         <= '0;
      rec_full        <= 1'b0;
      overrun         <= 1'b0;
      underrun        <= 1'b0;
      play_done       <= 1'b0;
    end else begin
      dac_valid <= 1'b0;

      // The DAC is answered every request; an empty prefetch yields silence.
      if (dac_req) begin
        dac_valid <= 1'b1;
        if (pf_vld) begin
          dac_data <= pf_data;
          pf_vld   <= 1'b0;
        end else begin
          dac_data <= '0;
          if (!play_done) underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (record_en) begin
            state <= REC_IDLE;
          end else if (play_en) begin
            // A word retained from an earlier play session is delivered before fetching more.
            state <= (pf_vld && !dac_req) ? PLAY_READY : PLAY_FETCH;
          end
        end

        REC_IDLE: begin
          // A sample coinciding with an address clear is not written, so it cannot land at a stale address.
          if (adc_valid && !rec_full && !sdr_waddr_set) begin
            sdr.sdr_wr_req  <= 1'b1;
            sdr.sdr_wr_addr <= waddr;
            sdr.sdr_wr_data <= adc_data;
            state           <= REC_WR;
          end else if (!record_en) begin
            state <= IDLE;
          end
        end

        REC_WR: begin
          if (adc_valid) overrun <= 1'b1;
          if (sdr.sdr_wr_ack) begin
            sdr.sdr_wr_req <= 1'b0;
            rec_len        <= rec_len + 1'b1;
            if (waddr == MAX_ADDR) rec_full <= 1'b1;
            else                   waddr    <= waddr + 1'b1;
            state <= record_en ? REC_IDLE : IDLE;
          end
        end

        PLAY_FETCH: begin
          if (sdr.sdr_rd_req) begin
            if (sdr.sdr_rd_ack) begin
              sdr.sdr_rd_req <= 1'b0;
              state          <= PLAY_WAIT;
            end
          end else if (!play_en) begin
            state <= IDLE;
          end else if (raddr >= rec_len) begin
`ifdef LOOP_PLAY_EN
            if (rec_len != '0) raddr <= '0;
`else
            play_done <= 1'b1;
`endif
          end else if (!rclr) begin
            sdr.sdr_rd_req  <= 1'b1;
            sdr.sdr_rd_addr <= raddr;
          end
        end

        PLAY_WAIT: begin
          if (sdr.sdr_rd_valid) begin
            pf_data <= sdr.sdr_rd_data;
            pf_vld  <= 1'b1;
            raddr   <= raddr + 1'b1;
            state   <= play_en ? PLAY_READY : IDLE;
          end
        end

        PLAY_READY: begin
          // Refetch once the word is consumed or discarded by a read-address clear.
          if (dac_req || !pf_vld) state <= PLAY_FETCH;
          else if (!play_en)      state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Clears come last so they override any same-cycle update.
      if (wclr) begin
        waddr    <= '0;
        rec_len  <= '0;
        rec_full <= 1'b0;
        overrun  <= 1'b0;
      end
      if (rclr) begin
        raddr     <= '0;
        pf_vld    <= 1'b0;
        underrun  <= 1'b0;
        play_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_rec_play_ctrl.sv
// Scoreboard bench for audio_rec_play_ctrl with a behavioural SDRAM and recording model.
// Latency: checks dac_valid one cycle after dac_req and write requests in recording order.
// Backpressure: SDRAM ack and read-data delays are randomized per phase.
module tb_audio_rec_play_ctrl;
  localparam int          AW    = 22;
  localparam int          DW    = 32;
  localparam logic [21:0] MAXA  = 22'd7;
  localparam int          NFULL = 8;
`ifdef LOOP_PLAY_EN
  localparam logic        EXP_DONE = 1'b0;
`else
  localparam logic        EXP_DONE = 1'b1;
`endif

  logic          clk50M, reset_n;
  logic          record_en, play_en, sdr_waddr_set, sdr_raddr_set;
  logic [DW-1:0] adc_data, dac_data;
  logic          adc_valid, dac_req, dac_valid;
  logic [AW-1:0] rec_len;
  logic          rec_full, overrun, underrun, play_done;

  audio_rec_play_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sdr ();

  audio_rec_play_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAXA)) dut (
    .clk50M        (clk50M),
    .reset_n       (reset_n),
    .record_en     (record_en),
    .play_en       (play_en),
    .sdr_waddr_set (sdr_waddr_set),
    .sdr_raddr_set (sdr_raddr_set),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .dac_req       (dac_req),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid),
    .sdr           (sdr),
    .rec_len       (rec_len),
    .rec_full      (rec_full),
    .overrun       (overrun),
    .underrun      (underrun),
    .play_done     (play_done)
  );

  initial begin
    clk50M = 1'b0;
    forever #10 clk50M = ~clk50M;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and reference model of the recording.
  logic [63:0] wq[$];
  logic [31:0] dq[$];
  logic [31:0] rec_m [0:31];
  int          rec_n  = 0;
  int          play_k = 0;

  // SDRAM model controls and memory.
  int          wr_dly = 3, rd_dly = 1, rv_dly = 2;
  int          wr_acks = 0, rd_acks = 0;
  logic [31:0] mem [0:31];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual=0x%0h required=none", nm, act);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #1;
    end
  endtask

  task automatic wait_wr(input int target);
    int i;
    i = 0;
    while (wr_acks < target && i < 200) begin cyc(1); i++; end
    if (wr_acks < target) bad("wr_ack_timeout", 64'(wr_acks));
  endtask

  task automatic wait_rd(input int target);
    int i;
    i = 0;
    while (rd_acks < target && i < 200) begin cyc(1); i++; end
    if (rd_acks < target) bad("rd_ack_timeout", 64'(rd_acks));
  endtask

  task automatic pulse_adc(input logic [31:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    cyc(1);
    adc_valid = 1'b0;
  endtask

  task automatic pulse_waddr();
    sdr_waddr_set = 1'b1;
    cyc(1);
    sdr_waddr_set = 1'b0;
    rec_n = 0;
    cyc(1);
  endtask

  task automatic pulse_raddr();
    sdr_raddr_set = 1'b1;
    cyc(1);
    sdr_raddr_set = 1'b0;
    play_k = 0;
    cyc(1);
  endtask

  task automatic push_wr(input int addr, input logic [31:0] d);
    wq.push_back((64'(addr) << 32) | 64'(d));
  endtask

  // One ADC sample: written at the next free word unless the buffer is full.
  task automatic rec_sample(input logic [31:0] d);
    int base;
    base = wr_acks;
    if (rec_n <= int'(MAXA)) begin
      push_wr(rec_n, d);
      rec_m[rec_n] = d;
      rec_n++;
      pulse_adc(d);
      wait_wr(base + 1);
    end else begin
      pulse_adc(d);
      cyc(5);
    end
  endtask

  // Next sample the DAC should hear when a prefetched word is due.
  function automatic logic [31:0] next_play();
    logic [31:0] v;
    v = 32'd0;
`ifdef LOOP_PLAY_EN
    if (rec_n != 0) begin
      v = rec_m[play_k % rec_n];
      play_k++;
    end
`else
    if (play_k < rec_n) begin
      v = rec_m[play_k];
      play_k++;
    end
`endif
    return v;
  endfunction

  task automatic dac_request(input logic [31:0] e);
    dq.push_back(e);
    dac_req = 1'b1;
    cyc(1);
    dac_req = 1'b0;
  endtask

  // Behavioural SDRAM: delayed acks, read data delivered rv_dly cycles after the read ack.
  initial begin
    int          wc, rc, vc;
    bit          pend;
    logic [4:0]  pa;
    wc = 0; rc = 0; vc = 0; pend = 0; pa = '0;
    sdr.sdr_wr_ack   = 1'b0;
    sdr.sdr_rd_ack   = 1'b0;
    sdr.sdr_rd_valid = 1'b0;
    sdr.sdr_rd_data  = '0;
    forever begin
      @(negedge clk50M);
      sdr.sdr_wr_ack   = 1'b0;
      sdr.sdr_rd_ack   = 1'b0;
      sdr.sdr_rd_valid = 1'b0;
      if (!reset_n) begin
        wc = 0; rc = 0; pend = 0;
      end else begin
        if (sdr.sdr_wr_req) begin
          if (wc >= wr_dly) begin
            sdr.sdr_wr_ack = 1'b1;
            mem[sdr.sdr_wr_addr[4:0]] = sdr.sdr_wr_data;
            wc = 0;
            wr_acks++;
          end else wc++;
        end
        if (pend) begin
          vc--;
          if (vc <= 0) begin
            sdr.sdr_rd_valid = 1'b1;
            sdr.sdr_rd_data  = mem[pa];
            pend = 0;
          end
        end else if (sdr.sdr_rd_req) begin
          if (rc >= rd_dly) begin
            sdr.sdr_rd_ack = 1'b1;
            pa   = sdr.sdr_rd_addr[4:0];
            pend = 1;
            vc   = rv_dly;
            rc   = 0;
            rd_acks++;
          end else rc++;
        end
      end
    end
  end

  // Write monitor: every new write request must match the oldest expected write.
  initial begin
    logic        prev_wreq;
    logic [63:0] act;
    prev_wreq = 1'b0;
    forever begin
      @(negedge clk50M);
      if (sdr.sdr_wr_req && !prev_wreq) begin
        act = (64'(sdr.sdr_wr_addr) << 32) | 64'(sdr.sdr_wr_data);
        if (wq.size() == 0) bad("wr_unexpected", act);
        else                chk("wr_addr_data", act, wq.pop_front());
      end
      prev_wreq = sdr.sdr_wr_req;
    end
  end

  // DAC monitor: every dac_valid strobe must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk50M);
      if (dac_valid) begin
        if (dq.size() == 0) bad("dac_unexpected", 64'(dac_data));
        else                chk("dac_data", 64'(dac_data), 64'(dq.pop_front()));
      end
    end
  end

  initial begin
    int          base, i;
    logic [31:0] d;
    record_en = 0; play_en = 0; sdr_waddr_set = 0; sdr_raddr_set = 0;
    adc_data = '0; adc_valid = 0; dac_req = 0;
    reset_n = 1'b0;
    cyc(3);
    chk("rst_dac_valid", 64'(dac_valid), 64'd0);
    chk("rst_dac_data",  64'(dac_data), 64'd0);
    chk("rst_wr_req",    64'(sdr.sdr_wr_req), 64'd0);
    chk("rst_rd_req",    64'(sdr.sdr_rd_req), 64'd0);
    chk("rst_rec_len",   64'(rec_len), 64'd0);
    chk("rst_flags",     64'({rec_full, overrun, underrun, play_done}), 64'd0);
    reset_n = 1'b1;
    cyc(2);

    // Overrun: second sample lands while the first write is still waiting for ack.
    record_en = 1'b1;
    cyc(2);
    wr_dly = 5;
    base = wr_acks;
    d = $urandom;
    push_wr(0, d);
    pulse_adc(d);
    cyc(1);
    pulse_adc($urandom);
    wait_wr(base + 1);
    cyc(2);
    chk("ovr_overrun", 64'(overrun), 64'd1);
    chk("ovr_rec_len", 64'(rec_len), 64'd1);

    pulse_waddr();
    chk("wclr_rec_len", 64'(rec_len), 64'd0);
    chk("wclr_overrun", 64'(overrun), 64'd0);

    // Four-sample recording with randomized ack delays.
    for (int k = 0; k < 4; k++) begin
      wr_dly = $urandom_range(1, 5);
      rec_sample(32'(k + 1) * 32'h11110000);
      cyc($urandom_range(0, 3));
    end
    cyc(1);
    chk("rec4_rec_len",  64'(rec_len), 64'd4);
    chk("rec4_overrun",  64'(overrun), 64'd0);
    chk("rec4_rec_full", 64'(rec_full), 64'd0);
    record_en = 1'b0;
    cyc(2);

    // Playback with a request every 20 cycles, running one past the end.
    rd_dly = $urandom_range(0, 3);
    rv_dly = $urandom_range(1, 4);
    pulse_raddr();
    play_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(20);
      dac_request(next_play());
    end
    cyc(5);
    chk("play_done",     64'(play_done), 64'(EXP_DONE));
    chk("play_underrun", 64'(underrun), 64'd0);

    // Underrun: request while the read data is still 30 cycles away.
    play_en = 1'b0;
    cyc(15);
    rd_dly = 1;
    rv_dly = 30;
    pulse_raddr();
    chk("rclr_play_done", 64'(play_done), 64'd0);
    play_en = 1'b1;
    base = rd_acks;
    wait_rd(base + 1);
    cyc(2);
    dac_request(32'd0);
    cyc(40);
    dac_request(next_play());
    cyc(3);
    chk("udr_underrun", 64'(underrun), 64'd1);
    rv_dly = 2;

    // Fill the buffer, then offer two more samples that must be ignored.
    play_en = 1'b0;
    cyc(40);
    pulse_waddr();
    chk("full_clr_len", 64'(rec_len), 64'd0);
    record_en = 1'b1;
    cyc(1);
    base = wr_acks;
    for (int k = 0; k < NFULL + 2; k++) begin
      wr_dly = $urandom_range(0, 4);
      rec_sample($urandom);
      cyc($urandom_range(0, 2));
    end
    cyc(3);
    chk("full_rec_full", 64'(rec_full), 64'd1);
    chk("full_rec_len",  64'(rec_len), 64'(NFULL));
    chk("full_overrun",  64'(overrun), 64'd0);
    chk("full_writes",   64'(wr_acks - base), 64'(NFULL));
    record_en = 1'b0;
    cyc(2);

    // Randomly paced playback of the full buffer and past its end.
    rd_dly = $urandom_range(0, 3);
    rv_dly = $urandom_range(1, 4);
    pulse_raddr();
    play_en = 1'b1;
    for (int k = 0; k < NFULL + 2; k++) begin
      cyc($urandom_range(22, 30));
      dac_request(next_play());
    end
    cyc(5);
    chk("full_play_done", 64'(play_done), 64'(EXP_DONE));
    chk("full_underrun",  64'(underrun), 64'd0);
    play_en = 1'b0;
    cyc(20);

    // Asynchronous reset while a write request is held.
    pulse_waddr();
    record_en = 1'b1;
    cyc(1);
    wr_dly = 20;
    d = $urandom;
    push_wr(0, d);
    pulse_adc(d);
    i = 0;
    while (!sdr.sdr_wr_req && i < 20) begin cyc(1); i++; end
    if (!sdr.sdr_wr_req) bad("wr_req_timeout", 64'd0);
    cyc(3);
    #5 reset_n = 1'b0;
    #1;
    chk("arst_wr_req",   64'(sdr.sdr_wr_req), 64'd0);
    chk("arst_wr_addr",  64'(sdr.sdr_wr_addr), 64'd0);
    chk("arst_wr_data",  64'(sdr.sdr_wr_data), 64'd0);
    chk("arst_dac_data", 64'(dac_data), 64'd0);
    chk("arst_rec_len",  64'(rec_len), 64'd0);
    chk("arst_flags",    64'({rec_full, overrun, underrun, play_done}), 64'd0);
    record_en = 1'b0;
    rec_n = 0;
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    chk("post_rst_wr_req", 64'(sdr.sdr_wr_req), 64'd0);
    chk("post_rst_rd_req", 64'(sdr.sdr_rd_req), 64'd0);

    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("dq_drained", 64'(dq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
